id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus load-use hazard detection for the 5-stage MIPS core.
//  Captures decoded operands, register addresses and control from ID each cycle.
//  Feeds ex_rs/ex_rt/ex_* directly to the EX-stage forwarding unit and ALU muxes.
//  Inserts one bubble and stalls PC/IF-ID when a load in EX feeds the instruction in ID.
// PARAMETERS
//  DATA_W    32  operand / immediate width
//  RADDR_W   5   register address width
//  CNT_W     16  width of saturating stall-cycle counter
// PORTS
//  clk           in   1        core clock, rising edge
//  reset         in   1        asynchronous, active-high reset
//  hold          in   1        global freeze (memory wait); ID/EX keeps contents
//  flush         in   1        squash instruction in ID (taken branch/jump)
//  id_rs         in   RADDR_W  rs address of instruction in ID
//  id_rt         in   RADDR_W  rt address in ID
//  id_rd         in   RADDR_W  rd address in ID
//  id_uses_rt    in   1        instruction in ID reads rt as a source
//  id_rs_data    in   DATA_W   register-file rs value
//  id_rt_data    in   DATA_W   register-file rt value
//  id_imm        in   DATA_W   sign-extended immediate
//  id_ctrl       in   8        {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegDst,ALUOp[1:0]}
//  ex_rs/ex_rt/ex_rd out RADDR_W  registered addresses (to forwarding unit, dest mux)
//  ex_rs_data/ex_rt_data/ex_imm out DATA_W registered operands
//  ex_ctrl       out  8        registered control, same packing as id_ctrl
//  ex_valid      out  1        1 = real instruction in EX, 0 = bubble
//  stall         out  1        hold PC and IF/ID this cycle (combinational)
//  stall_count   out  CNT_W    number of bubble cycles inserted, saturating
// BEHAVIOUR
//  Reset (async): all ex_* outputs 0, ex_valid 0, stall_count 0; stall 0 while reset high.
//  hazard = ex_valid & ex_ctrl.MemRead & (ex_rt!=0) &
//           ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
//  stall  = hazard & ~flush & ~hold (combinational from registered ex_* and ID inputs).
//  Per-edge update priority (highest first):
//   1 hold:   all ex_* and stall_count unchanged; stall output forced 0.
//   2 flush:  load bubble: ex_ctrl 0, ex_valid 0; addresses/data 0.
//   3 hazard: load bubble as above; stall_count += 1 (saturate at all-ones).
//   4 else:   capture id_* into ex_*, ex_valid 1.
//  Bubble must zero RegWrite/MemWrite so downstream forwarding never matches it.
//  Latency: ID inputs visible on ex_* one cycle later; load-use costs exactly 1 bubble.
//  Stall lasts one cycle: after bubble, ex_valid=0 so hazard clears; stalled ID instr
//   (held upstream) is captured on the next edge.
//  Register 0 as load destination never stalls.
//  Back-to-back loads with dependence: each dependent pair costs 1 bubble, no more.
//  hold and flush together: hold wins; flush must be re-presented by its source.
//  Reset mid-stall: outputs clear immediately; no bubble pending after release.
//  Simple 2-state view: RUN <-> BUBBLE (BUBBLE when ex_valid=0 due to hazard); no
//   other state; no multi-cycle sequences.
// STRUCTURE
//  Shared package/header: CTRL_* bit indices for the 8-bit control bundle, CTRL_W=8,
//   CTRL_BUBBLE=8'h00, RADDR_W, DATA_W.
//  One sub-module: load_use_detect (pure comb: hazard from ex_valid/MemRead/ex_rt/id_rs/id_rt).
//  Pipeline register and counter in the top; single always block, async reset.
// TESTING
//  T1 reset: assert reset mid-run -> all ex_* 0, ex_valid 0, stall 0, stall_count 0 at once.
//  T2 lw $8 then add $9,$8,$10 -> cycle after lw reaches EX: stall=1, next ex_valid=0,
//     ex_ctrl=0, stall_count=1; following edge captures add with ex_rs=8.
//  T3 lw $0 then add $9,$0,$1 -> stall never asserts, stall_count stays 0.
//  T4 lw $8 then sw using rt=8 (id_uses_rt=1) -> stall; same with id_uses_rt=0 -> no stall.
//  T5 hazard + flush same cycle -> stall=0, bubble loaded, stall_count unchanged.
//  T6 hold=1 for 3 cycles with hazard present -> ex_* frozen, stall=0, count frozen;
//     hold drops -> stall=1, one bubble, count+1; saturation check with count preset max.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared widths and control-bundle layout for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 8;

    // Bit positions inside {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegDst,ALUOp[1:0]}
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    // A bubble carries no RegWrite/MemWrite, so forwarding and memory ignore it.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID. Purely combinational.
module load_use_detect #(
    parameter int RADDR_W = 5
) (
    input  logic               ex_valid,
    input  logic               ex_mem_read,
    input  logic [RADDR_W-1:0] ex_rt,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               id_uses_rt,
    output logic               hazard
);

    logic rs_match;
    logic rt_match;

    // $zero as load destination never creates a dependence.
    always_comb begin
        rs_match = (ex_rt == id_rs);
        rt_match = id_uses_rt && (ex_rt == id_rt);
        hazard   = ex_valid && ex_mem_read && (ex_rt != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
//
//  state  | meaning
//  RUN    | ex_* holds the instruction captured from ID (ex_valid=1)
//  BUBBLE | ex_* zeroed after a load-use stall or flush (ex_valid=0)
//
// The state is implicit in ex_valid; a bubble clears the hazard by itself, so a
// load-use pair never costs more than one cycle.
module id_ex_stage #(
    parameter int DATA_W  = id_ex_stage_pkg::DATA_W,
    parameter int RADDR_W = id_ex_stage_pkg::RADDR_W,
    parameter int CNT_W   = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                hold,
    input  logic                                flush,
    input  logic [RADDR_W-1:0]                  id_rs,
    input  logic [RADDR_W-1:0]                  id_rt,
    input  logic [RADDR_W-1:0]                  id_rd,
    input  logic                                id_uses_rt,
    input  logic [DATA_W-1:0]                   id_rs_data,
    input  logic [DATA_W-1:0]                   id_rt_data,
    input  logic [DATA_W-1:0]                   id_imm,
    input  logic [id_ex_stage_pkg::CTRL_W-1:0]  id_ctrl,
    output logic [RADDR_W-1:0]                  ex_rs,
    output logic [RADDR_W-1:0]                  ex_rt,
    output logic [RADDR_W-1:0]                  ex_rd,
    output logic [DATA_W-1:0]                   ex_rs_data,
    output logic [DATA_W-1:0]                   ex_rt_data,
    output logic [DATA_W-1:0]                   ex_imm,
    output logic [id_ex_stage_pkg::CTRL_W-1:0]  ex_ctrl,
    output logic                                ex_valid,
    output logic                                stall,
    output logic [CNT_W-1:0]                    stall_count
);

    import id_ex_stage_pkg::*;

    logic hazard;

    load_use_detect #(
        .RADDR_W (RADDR_W)
    ) u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .hazard      (hazard)
    );

    // Stall only when this edge will actually insert a hazard bubble.
    always_comb begin
        stall = hazard && !flush && !hold;
    end

    // Pipeline register and saturating bubble counter: hold > flush > hazard > capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= CTRL_BUBBLE;
            ex_valid    <= 1'b0;
            stall_count <= '0;
        end else if (hold) begin
            // freeze everything
        end else if (flush || hazard) begin
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_ctrl    <= CTRL_BUBBLE;
            ex_valid   <= 1'b0;
            // a flush squashes ID anyway, so only a genuine load-use bubble is counted
            if (!flush && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end else begin
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_ctrl    <= id_ctrl;
            ex_valid   <= 1'b1;
        end
    end

endmodule
